poly_mod_add_stream: RTL



---
 rtl/he_pkg.sv | 32 +++
 rtl/result_skid_fifo.sv | 58 +++++
 rtl/poly_mod_add_stream.sv | 122 ++++++++++++
 3 files changed

// File: rtl/he_pkg.sv
// Shared types and the modular-add helper for the polynomial add stream.
// Widths here are the build-time defaults; the top checks that its parameters match them.
package he_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned LogN      = 4;

  typedef logic [DataWidth-1:0] coeff_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    coeff_t             data;
    logic [LogN-1:0]    index;
    logic               last;
  } result_entry_t;

  // One conditional subtraction; out-of-range operands are not reduced further.
  function automatic coeff_t mod_add(coeff_t a, coeff_t b, coeff_t m);
    logic [DataWidth:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) begin
      sum = sum - {1'b0, m};
    end
    return sum[DataWidth-1:0];
  endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry synchronous FIFO holding finished results; head is read straight from storage.
module result_skid_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [2];
  logic             wptr_q, rptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // A push while full is only legal alongside a pop, which frees the slot being written.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/poly_mod_add_stream.sv
// Streams N coefficient pairs through (a+b) mod m with run control and a 2-entry result buffer.
// in_ready depends only on registered state, so back-pressure never forms a comb path upstream.
module poly_mod_add_stream
  import he_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOG_N      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] modulus,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LOG_N-1:0]      out_index,
  output logic                  out_last
);

  if (DATA_WIDTH != DataWidth || LOG_N != LogN) begin : g_param_check
    $error("poly_mod_add_stream parameters must match he_pkg widths");
  end

  localparam logic [LOG_N-1:0] LastIndex = {LOG_N{1'b1}};

  state_e          state_q, state_d;
  logic [LOG_N-1:0] in_cnt_q, in_cnt_d;
  coeff_t          mod_q, mod_d;
  logic            done_q, done_d;

  result_entry_t   wr_entry;
  result_entry_t   head;
  logic            fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [1:0]      fifo_count;

  logic            in_fire, out_fire, last_in;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_in  = (in_cnt_q == LastIndex);

  assign wr_entry = '{data: mod_add(in_a, in_b, mod_q), index: in_cnt_q, last: last_in};

  assign fifo_push = in_fire;
  assign fifo_pop  = out_ready && !fifo_empty;

  result_skid_fifo #(
    .Width($bits(result_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(wr_entry),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (in_fire && last_in) state_d = StDrain;
      StDrain: if (out_fire && head.last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    in_ready = (state_q == StRun) && !fifo_full;
  end

  // Modulus is captured only on the accepted start; later port changes do not matter.
  always_comb begin
    mod_d    = mod_q;
    in_cnt_d = in_cnt_q;
    if (state_q == StIdle && start) begin
      mod_d    = modulus;
      in_cnt_d = '0;
    end else if (in_fire) begin
      in_cnt_d = in_cnt_q + 1'b1;
    end
    done_d = (state_q == StDrain) && out_fire && head.last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q <= '0;
      mod_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      in_cnt_q <= in_cnt_d;
      mod_q    <= mod_d;
      done_q   <= done_d;
    end
  end

  assign done      = done_q;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = head.data;
  assign out_index = head.index;
  assign out_last  = head.last;

endmodule
